mem_stage: RTL and testbench

- Memory stage of the 5-stage pipeline; consumes the X/M register outputs (control, dst, ALU address/result, store value, store source register).
- Performs loads/stores over a variable-latency req/ack data-memory port, stalling upstream until completion.
- Forwards write-back data into store data; formats byte/word accesses.
- Produces the registered write-back bundle consumed by the M/W stage.

---
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the memory stage and the data memory.
// Latency: none, wires only.
// Backpressure: the requester holds req and its fields until the memory returns ack.
// Ports (master = requester): req, we, be, addr, wdata out; ack, rdata in.
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on a req/ack data port, formats byte/word data, registers the write-back bundle.
// Latency: 1 cycle for non-memory ops; launch cycle + wait cycles + 1 for memory ops (minimum 2).
// Backpressure: stall is raised combinationally while a memory op is pending; upstream holds m_* until it drops.
// Ports: clk/rst; m_* operation from X/M; wb_* forwarding source; dmem master port; stall; w_* and misalign to M/W.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_read,
    input  logic              m_write,
    input  logic              m_byte,
    input  logic              m_signed,
    input  logic              m_reg_we,
    input  logic [REG_W-1:0]  m_dst,
    input  logic [DATA_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_val,
    input  logic [REG_W-1:0]  m_src,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_dst,
    input  logic [DATA_W-1:0] wb_val,
    mem_stage_if.master       dmem,
    output logic              stall,
    output logic              w_we,
    output logic [REG_W-1:0]  w_dst,
    output logic [DATA_W-1:0] w_data,
    output logic              misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic              req_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        lane_q;
    logic              byte_q;
    logic              signed_q;
    logic              load_q;

    logic              any_op;
    logic              unaligned;
    logic              misal_op;
    logic              mem_op;
    logic [DATA_W-1:0] store_src;
    logic [DATA_W-1:0] store_fmt;
    logic [7:0]        load_lane;
    logic [DATA_W-1:0] load_fmt;

    assign any_op    = m_read | m_write;
    assign unaligned = (m_addr[1:0] != 2'b00);
    // Word accesses must be aligned; byte accesses may hit any lane.
    assign misal_op  = any_op & ~m_byte & unaligned;
    assign mem_op    = any_op & ~misal_op;

    // A register being written back this cycle is newer than the X/M copy.
    assign store_src = (wb_en && (wb_dst == m_src) && (m_src != '0)) ? wb_val : m_val;
    assign store_fmt = m_byte ? {(DATA_W/8){store_src[7:0]}} : store_src;

    // Byte loads pick the lane addressed by the latched low address bits.
    assign load_lane = 8'(dmem.rdata >> {lane_q, 3'b000});
    assign load_fmt  = byte_q ? {{(DATA_W-8){signed_q & load_lane[7]}}, load_lane}
                              : dmem.rdata;

    // The ack cycle releases upstream so the completing op retires on the next edge.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = mem_op;
            BUSY:    stall = ~dmem.ack;
            default: stall = 1'b0;
        endcase
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.be    = be_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lane_q   <= 2'b00;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            load_q   <= 1'b0;
            w_we     <= 1'b0;
            w_dst    <= '0;
            w_data   <= '0;
            misalign <= 1'b0;
        end else begin
            // Default is a bubble; only retiring ops overwrite it.
            w_we     <= 1'b0;
            w_dst    <= '0;
            w_data   <= '0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state    <= BUSY;
                        req_q    <= 1'b1;
                        we_q     <= m_write;
                        be_q     <= m_byte ? 4'(4'b0001 << m_addr[1:0]) : 4'hF;
                        addr_q   <= {m_addr[DATA_W-1:2], 2'b00};
                        wdata_q  <= store_fmt;
                        lane_q   <= m_addr[1:0];
                        byte_q   <= m_byte;
                        signed_q <= m_signed;
                        load_q   <= m_read;
                    end else if (misal_op) begin
                        misalign <= 1'b1;
                    end else begin
                        w_we   <= m_reg_we;
                        w_dst  <= m_dst;
                        w_data <= m_addr;
                    end
                end
                BUSY: begin
                    if (dmem.ack) begin
                        state  <= IDLE;
                        req_q  <= 1'b0;
                        w_we   <= m_reg_we;
                        w_dst  <= m_dst;
                        w_data <= load_q ? load_fmt : m_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard and a scripted data memory.
// Latency: n/a.
// Backpressure: the bench holds m_* while stall is high and answers requests after a chosen wait.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_read, m_write, m_byte, m_signed, m_reg_we;
    logic [4:0]  m_dst, m_src;
    logic [31:0] m_addr, m_val;
    logic        wb_en;
    logic [4:0]  wb_dst;
    logic [31:0] wb_val;
    logic        stall, w_we, misalign;
    logic [4:0]  w_dst;
    logic [31:0] w_data;

    mem_stage_if #(.DATA_W(32)) dmem_bus ();

    mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .m_read   (m_read),
        .m_write  (m_write),
        .m_byte   (m_byte),
        .m_signed (m_signed),
        .m_reg_we (m_reg_we),
        .m_dst    (m_dst),
        .m_addr   (m_addr),
        .m_val    (m_val),
        .m_src    (m_src),
        .wb_en    (wb_en),
        .wb_dst   (wb_dst),
        .wb_val   (wb_val),
        .dmem     (dmem_bus.master),
        .stall    (stall),
        .w_we     (w_we),
        .w_dst    (w_dst),
        .w_data   (w_data),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  dst;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m_read = 0; m_write = 0; m_byte = 0; m_signed = 0; m_reg_we = 0;
        m_dst = 0; m_src = 0; m_addr = 0; m_val = 0;
        wb_en = 0; wb_dst = 0; wb_val = 0;
    endtask

    // Called at posedge+1. Drives one op, plays the memory for wait_n
    // non-ack BUSY cycles then acks, and checks the retired bundle.
    task automatic run_op(
        input string tag,
        input logic rd, input logic wr, input logic byt, input logic sgn, input logic rwe,
        input logic [4:0] dst, input logic [31:0] addr, input logic [31:0] val, input logic [4:0] src,
        input logic wbe, input logic [4:0] wbd, input logic [31:0] wbv,
        input int wait_n, input logic [31:0] rdata,
        input logic exp_mem, input logic exp_dwe, input logic [3:0] exp_be,
        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
        input logic exp_we, input logic [4:0] exp_dst, input logic [31:0] exp_data, input logic exp_mis);
        exp_t e;
        m_read = rd; m_write = wr; m_byte = byt; m_signed = sgn; m_reg_we = rwe;
        m_dst = dst; m_addr = addr; m_val = val; m_src = src;
        wb_en = wbe; wb_dst = wbd; wb_val = wbv;
        sb.push_back({exp_we, exp_dst, exp_data, exp_mis});
        #1;
        chk({tag, ".stall_launch"}, stall, exp_mem);
        if (exp_mem) begin
            for (int i = 0; i <= wait_n; i++) begin
                @(posedge clk); #1;
                // Forwarding source changes after launch must not leak in.
                wb_en = 0; wb_val = 32'hFFFF_FFFF;
                chk({tag, ".bubble_we"}, w_we, 1'b0);
                chk({tag, ".bubble_data"}, w_data, 32'h0);
                chk({tag, ".req"}, dmem_bus.req, 1'b1);
                chk({tag, ".addr"}, dmem_bus.addr, exp_addr);
                chk({tag, ".be"}, dmem_bus.be, exp_be);
                chk({tag, ".we"}, dmem_bus.we, exp_dwe);
                chk({tag, ".wdata"}, dmem_bus.wdata, exp_wdata);
                if (i == wait_n) begin
                    dmem_bus.ack = 1; dmem_bus.rdata = rdata;
                end
                #1;
                chk({tag, ".stall_busy"}, stall, (i == wait_n) ? 1'b0 : 1'b1);
            end
        end
        @(posedge clk); #1;
        dmem_bus.ack = 0; dmem_bus.rdata = 32'h0;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s.sb_empty observed=0 expected=1", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".w_we"}, w_we, e.we);
            chk({tag, ".w_dst"}, w_dst, e.dst);
            chk({tag, ".w_data"}, w_data, e.data);
            chk({tag, ".misalign"}, misalign, e.mis);
        end
        chk({tag, ".req_done"}, dmem_bus.req, 1'b0);
    endtask

    initial begin
        idle_inputs();
        dmem_bus.ack = 0; dmem_bus.rdata = 0;
        rst = 1;
        m_read = 1; m_addr = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.stall_comb", stall, 1'b1);
        chk("rst.w_we", w_we, 1'b0);
        chk("rst.w_dst", w_dst, 5'd0);
        chk("rst.w_data", w_data, 32'h0);
        chk("rst.misalign", misalign, 1'b0);
        chk("rst.req", dmem_bus.req, 1'b0);
        chk("rst.we", dmem_bus.we, 1'b0);
        chk("rst.be", dmem_bus.be, 4'h0);
        chk("rst.addr", dmem_bus.addr, 32'h0);
        chk("rst.wdata", dmem_bus.wdata, 32'h0);
        idle_inputs();
        rst = 0;

        //      tag      rd wr by sg rwe dst  addr          val           src wbe wbd wbv       wait rdata          mem dwe be       daddr     dwdata        we dst data          mis
        run_op("alu",    0, 0, 0, 0, 1,  5,  32'h1234,     32'h0,        0,  0,  0,  32'h0,    0,   32'h0,         0,  0,  4'h0,    32'h0,    32'h0,        1, 5,  32'h1234,     0);
        run_op("ldw",    1, 0, 0, 0, 1,  9,  32'h100,      32'h0,        0,  0,  0,  32'h0,    3,   32'hDEADBEEF,  1,  0,  4'hF,    32'h100,  32'h0,        1, 9,  32'hDEADBEEF, 0);
        run_op("ldbs",   1, 0, 1, 1, 1,  10, 32'h103,      32'h0,        0,  0,  0,  32'h0,    0,   32'h80FFFFFF,  1,  0,  4'b1000, 32'h100,  32'h0,        1, 10, 32'hFFFFFF80, 0);
        run_op("ldbu",   1, 0, 1, 0, 1,  11, 32'h103,      32'h0,        0,  0,  0,  32'h0,    1,   32'h80FFFFFF,  1,  0,  4'b1000, 32'h100,  32'h0,        1, 11, 32'h00000080, 0);
        run_op("ldb1",   1, 0, 1, 0, 1,  12, 32'h101,      32'h0,        0,  0,  0,  32'h0,    0,   32'h0000C300,  1,  0,  4'b0010, 32'h100,  32'h0,        1, 12, 32'h000000C3, 0);
        run_op("ldbp",   1, 0, 1, 1, 1,  13, 32'h104,      32'h0,        0,  0,  0,  32'h0,    2,   32'h1234567F,  1,  0,  4'b0001, 32'h104,  32'h0,        1, 13, 32'h0000007F, 0);
        run_op("stb",    0, 1, 1, 0, 0,  0,  32'h102,      32'hAB,       3,  0,  0,  32'h0,    2,   32'h0,         1,  1,  4'b0100, 32'h100,  32'hABABABAB, 0, 0,  32'h102,      0);
        run_op("stfwd",  0, 1, 0, 0, 0,  0,  32'h200,      32'h1,        7,  1,  7,  32'h55,   1,   32'h0,         1,  1,  4'hF,    32'h200,  32'h55,       0, 0,  32'h200,      0);
        run_op("str0",   0, 1, 0, 0, 0,  0,  32'h204,      32'h12345678, 0,  1,  0,  32'h55,   0,   32'h0,         1,  1,  4'hF,    32'h204,  32'h12345678, 0, 0,  32'h204,      0);
        run_op("mis",    1, 0, 0, 0, 1,  4,  32'h102,      32'h0,        0,  0,  0,  32'h0,    0,   32'h0,         0,  0,  4'h0,    32'h0,    32'h0,        0, 0,  32'h0,        1);
        run_op("alu2",   0, 0, 0, 0, 1,  6,  32'hBEEF,     32'h0,        0,  0,  0,  32'h0,    0,   32'h0,         0,  0,  4'h0,    32'h0,    32'h0,        1, 6,  32'hBEEF,     0);

        // Reset while a load is outstanding, then a stray ack.
        m_read = 1; m_reg_we = 1; m_dst = 8; m_addr = 32'h300;
        #1;
        chk("rbusy.stall_launch", stall, 1'b1);
        @(posedge clk); #1;
        chk("rbusy.req", dmem_bus.req, 1'b1);
        rst = 1;
        idle_inputs();
        @(posedge clk); #1;
        chk("rbusy.req_after_rst", dmem_bus.req, 1'b0);
        chk("rbusy.w_we_after_rst", w_we, 1'b0);
        rst = 0;
        dmem_bus.ack = 1; dmem_bus.rdata = 32'h12345678;
        #1;
        chk("stray.stall", stall, 1'b0);
        @(posedge clk); #1;
        dmem_bus.ack = 0; dmem_bus.rdata = 0;
        chk("stray.w_we", w_we, 1'b0);
        chk("stray.w_dst", w_dst, 5'd0);
        chk("stray.w_data", w_data, 32'h0);
        chk("stray.req", dmem_bus.req, 1'b0);

        // Register 0 destination passes through unchanged.
        run_op("alu_r0", 0, 0, 0, 0, 1,  0,  32'hCAFE,     32'h0,        0,  0,  0,  32'h0,    0,   32'h0,         0,  0,  4'h0,    32'h0,    32'h0,        1, 0,  32'hCAFE,     0);
        idle_inputs();

        chk("sb.drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
